// File: rtl/mlp_pkg.sv
// mlp_pkg: shared constants and types for the MLP inference output stage
package mlp_pkg;
  localparam int DATA_W = 16;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W = $clog2(NUM_CLASSES);
  typedef logic signed [DATA_W-1:0] score_t;
  typedef logic [IDX_W-1:0] class_idx_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} argmax_state_e;
  localparam class_idx_t LAST_IDX = class_idx_t'(NUM_CLASSES - 1);
endpackage

// File: rtl/argmax_cmp.sv
// argmax_cmp: signed compare-and-select; cand replaces cur only when strictly greater
// ports: cur_best/cur_idx running best in, cand/cand_idx candidate in, new_best/new_idx selected out
module argmax_cmp
  import mlp_pkg::*;
(
  input  logic [DATA_W-1:0] cur_best,
  input  logic [IDX_W-1:0]  cur_idx,
  input  logic [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]  cand_idx,
  output logic [DATA_W-1:0] new_best,
  output logic [IDX_W-1:0]  new_idx
);
  logic take;
  assign take = $signed(cand) > $signed(cur_best);
  assign new_best = take ? cand : cur_best;
  assign new_idx = take ? cand_idx : cur_idx;
endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: streams NUM_CLASSES signed scores per frame and reports the argmax class
// ports: clk, rst_n (async low), clear (sync abort); in_valid/in_ready/in_score/in_last score beats;
//        out_valid/out_ready result handshake with out_class, out_err (framing) and, when
//        ARGMAX_SCORE_OUT_EN is defined, out_score (winning score)
module argmax_classifier
  import mlp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_score,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_class,
  output logic              out_err
`ifdef ARGMAX_SCORE_OUT_EN
  ,
  output logic [DATA_W-1:0] out_score
`endif
);
  argmax_state_e state, state_nx;
  logic [DATA_W-1:0] best, nb;
  logic [IDX_W-1:0] best_idx, ni, beat_cnt;
  logic err, acc, fin, ferr;
  assign in_ready = rst_n && state != DONE;
  assign out_valid = state == DONE;
  assign acc = in_valid && in_ready;
  assign fin = state == ACCUM && beat_cnt == LAST_IDX;
  assign ferr = in_last != fin;
  argmax_cmp u_cmp (
    .cur_best(best),
    .cur_idx (best_idx),
    .cand    (in_score),
    .cand_idx(beat_cnt),
    .new_best(nb),
    .new_idx (ni)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = clear ? IDLE :
               (state == IDLE && acc) ? ACCUM :
               (fin && acc) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_cnt <= '0;
      best <= '0;
      best_idx <= '0;
      err <= 1'b0;
      out_class <= '0;
      out_err <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
      err <= 1'b0;
    end else if (acc) begin
      best <= state == IDLE ? in_score : nb;
      best_idx <= state == IDLE ? '0 : ni;
      beat_cnt <= fin ? '0 : beat_cnt + 1'b1;
      err <= err | ferr;
      if (fin) begin
        out_class <= ni;
        out_err <= err | ferr;
      end
    end else if (state == DONE && out_ready) err <= 1'b0;
`ifdef ARGMAX_SCORE_OUT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_score <= '0;
    else if (!clear && acc && fin) out_score <= nb;
`endif
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed and random frames checked against a max-then-first-index model
module tb_argmax_classifier;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_score = '0;
  logic in_ready, out_valid, out_err;
  logic [3:0] out_class;
  logic [15:0] out_score;
  logic signed [15:0] sc[10];
  logic lst[10];
  logic [15:0] exp_s;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  argmax_classifier dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_score(in_score), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err)
`ifdef ARGMAX_SCORE_OUT_EN
    , .out_score(out_score)
`endif
  );
`ifndef ARGMAX_SCORE_OUT_EN
  assign out_score = '0;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(output int cls, output logic e);
    int mx = -32768;
    foreach (sc[i]) if (int'(sc[i]) > mx) mx = int'(sc[i]);
    cls = -1;
    foreach (sc[i]) if (cls < 0 && int'(sc[i]) == mx) cls = i;
    e = 0;
    foreach (lst[i]) if (lst[i] != (i == 9)) e = 1;
  endfunction
  task automatic beat(input logic [15:0] s, input logic l);
    int w = 0;
    in_valid = 1;
    in_score = s;
    in_last = l;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 20) chk("ready_wait", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic run_frame(input string tag, input int hold);
    int cls;
    logic e;
    model(cls, e);
    exp_s = sc[cls];
    out_ready = (hold == 0);
    for (int i = 0; i < 10; i++) begin
      chk({tag, "_early_valid"}, 32'(out_valid), 0);
      beat(sc[i], lst[i]);
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_class"}, 32'(out_class), 32'(cls));
    chk({tag, "_err"}, 32'(out_err), 32'(e));
`ifdef ARGMAX_SCORE_OUT_EN
    chk({tag, "_score"}, 32'(out_score), 32'(exp_s));
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 1);
      chk({tag, "_hold_ready"}, 32'(in_ready), 0);
      chk({tag, "_hold_class"}, 32'(out_class), 32'(cls));
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, "_release_valid"}, 32'(out_valid), 0);
    chk({tag, "_release_ready"}, 32'(in_ready), 1);
  endtask
  initial begin
    #1;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_class", 32'(out_class), 0);
    chk("rst_err", 32'(out_err), 0);
    #11 rst_n = 1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(in_ready), 1);
    sc = '{5, -3, 12, 7, 0, 1, -8, 11, 2, 4};
    foreach (lst[i]) lst[i] = (i == 9);
    run_frame("t1", 0);
    foreach (sc[i]) sc[i] = 16'sh8000;
    run_frame("t2", 0);
    sc = '{1, 9, 3, 9, 2, 0, -1, 5, 9, 8};
    run_frame("t3", 5);
    foreach (sc[i]) sc[i] = 16'($urandom);
    lst[4] = 1;
    run_frame("t4_err", 1);
    lst[4] = 0;
    foreach (sc[i]) sc[i] = 16'($urandom);
    run_frame("t4_clean", 0);
    for (int i = 0; i < 7; i++) beat(16'(100 + i), i == 3);
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    chk("t5_clear_valid", 32'(out_valid), 0);
    chk("t5_clear_ready", 32'(in_ready), 1);
    foreach (sc[i]) sc[i] = 16'($urandom_range(30000));
    sc[9] = 16'sh7fff;
    run_frame("t5", 2);
    for (int i = 0; i < 4; i++) beat(16'(i), 0);
    #3 rst_n = 0;
    #1;
    chk("t6_rst_ready", 32'(in_ready), 0);
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_class", 32'(out_class), 0);
    #12 rst_n = 1;
    @(posedge clk); #1;
    foreach (sc[i]) sc[i] = 16'($urandom);
    run_frame("t6", 1);
    for (int f = 0; f < 20; f++) begin
      foreach (sc[i]) sc[i] = 16'($urandom);
      if ($urandom_range(1) == 1) sc[$urandom_range(9, 5)] = sc[$urandom_range(4)];
      foreach (lst[i]) lst[i] = (i == 9);
      if ($urandom_range(3) == 0) begin
        int k = $urandom_range(9);
        lst[k] = ~lst[k];
      end
      run_frame("rnd", $urandom_range(3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
